// File: rtl/regwb_pkg.sv
// Shared widths, the queued-write entry type and a one-hot helper for the register write arbiter.
package regwb_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } regwb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] idx);
    reg_onehot      = '0;
    reg_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/regwb_fifo.sv
// Synchronous FIFO of pending aux register writes; exposes per-slot valid bits and
// destination indices so the arbiter can build its pending-destination mask.
module regwb_fifo import regwb_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 push_i,
  input  regwb_entry_t                         push_entry_i,
  input  logic                                 pop_i,
  output regwb_entry_t                         head_o,
  output logic [$clog2(DEPTH):0]               count_o,
  output logic                                 full_o,
  output logic                                 empty_o,
  output logic [DEPTH-1:0]                     valid_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]         entry_reg_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  regwb_entry_t   mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic           push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    vld_d   = vld_q;
    if (push_ok && !pop_ok) count_d = count_q + CW'(1);
    if (pop_ok && !push_ok) count_d = count_q - CW'(1);
    // push and pop never hit the same slot: that would need empty+pop or full+push
    if (pop_ok)  vld_d[rd_ptr_q] = 1'b0;
    if (push_ok) vld_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_reg_o[i] = mem_q[i].idx;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign valid_o = vld_q;

endmodule

// File: rtl/register_write_arbiter.sv
// Merges pipeline writebacks with buffered long-latency results onto one registered write port.
// Optional macro REGWB_AUX_BYPASS_EN lets an aux write skip an empty FIFO when the pipe is idle.
module register_write_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Pipe_Write,
  input  logic [ADDR_W-1:0]       Pipe_Reg,
  input  logic [DATA_W-1:0]       Pipe_Data,
  input  logic                    Aux_Valid,
  output logic                    Aux_Ready,
  input  logic [ADDR_W-1:0]       Aux_Reg,
  input  logic [DATA_W-1:0]       Aux_Data,
  output logic                    Register_Write,
  output logic [ADDR_W-1:0]       Write_Reg,
  output logic [DATA_W-1:0]       Register_Write_Data,
  output logic [31:0]             Pending_Mask,
  output logic [$clog2(DEPTH):0]  Fifo_Count
);

  import regwb_pkg::*;

  regwb_entry_t             fifo_head, push_entry;
  logic                     fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DEPTH-1:0]         fifo_vld;
  logic [DEPTH-1:0][ADDR_W-1:0] fifo_regs;

  logic                     pipe_ok, aux_nz, bypass;
  logic                     rw_q, rw_d, is_aux_q, is_aux_d;
  logic [ADDR_W-1:0]        wreg_q, wreg_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic [NUM_REGS-1:0]      mask;

  assign push_entry = '{idx: Aux_Reg, data: Aux_Data};

  regwb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (Clk),
    .rst_i        (Reset),
    .push_i       (fifo_push),
    .push_entry_i (push_entry),
    .pop_i        (fifo_pop),
    .head_o       (fifo_head),
    .count_o      (Fifo_Count),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .valid_o      (fifo_vld),
    .entry_reg_o  (fifo_regs)
  );

  // Ready comes from registered occupancy only, so a full FIFO stays not-ready even while popping.
  assign Aux_Ready = !fifo_full;

  always_comb begin
    pipe_ok = Pipe_Write && (Pipe_Reg != '0);
    // Accepted transfers to r0 are swallowed here and never reach the FIFO.
    aux_nz  = Aux_Valid && Aux_Ready && (Aux_Reg != '0);
`ifdef REGWB_AUX_BYPASS_EN
    bypass  = aux_nz && fifo_empty && !pipe_ok;
`else
    bypass  = 1'b0;
`endif
    fifo_push = aux_nz && !bypass;
    fifo_pop  = !pipe_ok && !fifo_empty;

    rw_d     = 1'b0;
    is_aux_d = 1'b0;
    wreg_d   = wreg_q;
    wdata_d  = wdata_q;
    if (pipe_ok) begin
      rw_d    = 1'b1;
      wreg_d  = Pipe_Reg;
      wdata_d = Pipe_Data;
    end else if (!fifo_empty) begin
      rw_d     = 1'b1;
      is_aux_d = 1'b1;
      wreg_d   = fifo_head.idx;
      wdata_d  = fifo_head.data;
    end else if (bypass) begin
      rw_d     = 1'b1;
      is_aux_d = 1'b1;
      wreg_d   = Aux_Reg;
      wdata_d  = Aux_Data;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rw_q     <= 1'b0;
      is_aux_q <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      rw_q     <= rw_d;
      is_aux_q <= is_aux_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_vld[i]) mask = mask | reg_onehot(fifo_regs[i]);
    end
    if (rw_q && is_aux_q) mask = mask | reg_onehot(wreg_q);
    mask[0] = 1'b0;
  end

  assign Pending_Mask        = mask;
  assign Register_Write      = rw_q;
  assign Write_Reg           = wreg_q;
  assign Register_Write_Data = wdata_q;

endmodule

// File: doc/register_write_arbiter.md
# register_write_arbiter

Single write-port arbiter sitting in front of the 32 x 32 register file's write side. It merges pipeline writebacks (highest priority, never stalled) with results from the long-latency unit (multiply/divide/load-miss) buffered in a small FIFO. It produces exactly one registered write per cycle on Register_Write / Write_Reg / Register_Write_Data. It also exports a pending-destination mask so the hazard unit can stall readers of registers with queued writes.

## Interface
- DEPTH, 4: aux FIFO entries; power of two, at least 2
- DATA_W, 32: write data width
- ADDR_W, 5: register index width
- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- Pipe_Write  in  1  pipeline writeback valid; always accepted
- Pipe_Reg  in  ADDR_W  pipeline destination register
- Pipe_Data  in  DATA_W  pipeline write data
- Aux_Valid  in  1  long-latency result valid
- Aux_Ready  out  1  FIFO can accept; transfer when Aux_Valid && Aux_Ready at a rising edge
- Aux_Reg  in  ADDR_W  aux destination register
- Aux_Data  in  DATA_W  aux write data
- Register_Write  out  1  write enable to register file
- Write_Reg  out  ADDR_W  destination index
- Register_Write_Data  out  DATA_W  write data
- Pending_Mask  out  32  bit r set if a queued or in-flight aux write targets r
- Fifo_Count  out  clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Output stage is a register: {Register_Write, Write_Reg, Register_Write_Data, Out_Is_Aux}.
- Each edge, the output stage loads with the following priority:
  1. Pipe_Write && Pipe_Reg != 0 loads the pipe write.
  2. Otherwise, a non-empty FIFO pops its head into the output stage.
  3. Otherwise, Register_Write <= 0.
- Aux push: an accepted transfer with Aux_Reg != 0 is enqueued. An accepted transfer with Aux_Reg == 0 is consumed and discarded: no enqueue, no write.
- Pipe write with Pipe_Reg == 0 counts as no pipe write; the FIFO may pop that cycle.
- Aux_Ready = (Fifo_Count < DEPTH), computed from registered count. A full FIFO is not ready even if it pops that cycle; there is no pass-through when full.
- Push and pop in the same cycle: count is unchanged and order is preserved (FIFO, pointers wrap modulo DEPTH).
- Pending_Mask = OR of onehot(reg) over valid FIFO entries, OR onehot(Write_Reg) if Register_Write && Out_Is_Aux. Bit 0 is always 0.
- No reordering or conflict checking. The hazard unit must not issue a pipe write to a register set in Pending_Mask.
- Sustained Pipe_Write starves the FIFO. Back-pressure via Aux_Ready is the only consequence; no data is lost.

## Timing
- Reset values: Register_Write 0, Write_Reg 0, Register_Write_Data 0, Out_Is_Aux 0, Fifo_Count 0, Pending_Mask 0, Aux_Ready 1 (after reset deasserts). FIFO pointers are 0.
- Reset mid-operation: all queued writes are dropped and the output write in progress is squashed immediately (asynchronous).
- Pipe latency: Pipe_Write sampled at edge N gives Register_Write high during cycle N+1. The register file commits it at edge N+1.
- Aux latency without bypass: accepted at edge N, popped at the earliest edge N+1, Register_Write high during cycle N+2.
- Pending_Mask bit sets in the cycle after acceptance. It clears in the cycle after the register file commit edge.

## Configuration
- REGWB_AUX_BYPASS_EN defined: an accepted aux write with Aux_Reg != 0 is not enqueued when, at that edge, the FIFO is empty and there is no valid pipe write. It loads the output stage directly, so Register_Write is high in cycle N+1. Fifo_Count stays 0.
- Not defined: all aux writes pass through the FIFO; minimum aux latency is 2 cycles.

## Structure
- Package regwb_pkg holds ADDR_W, DATA_W, NUM_REGS = 32, and a typedef regwb_entry_t {reg index, data}.
- Sub-module regwb_fifo: synchronous FIFO of regwb_entry_t, DEPTH entries, with push/pop/count/full/empty and an entry-valid vector for the mask OR.
- The arbiter top holds the priority mux, output stage, and mask logic.

## Test plan
- Reset, then Pipe_Write=1, Pipe_Reg=5, Pipe_Data=0xDEADBEEF at edge 1 -> Register_Write=1, Write_Reg=5, Register_Write_Data=0xDEADBEEF in cycle 2 only.
- Aux writes r3=0x11 and r4=0x22 on consecutive edges while Pipe_Write=0, no bypass -> writes r3 then r4 in cycles 3 and 4. Pending_Mask=0x18 at its peak, then 0x10, then 0 after the r4 commit.
- Pipe_Write held high for 6 cycles while Aux_Valid is held with r7..r12, DEPTH=4 -> four accepted, Aux_Ready=0 from Fifo_Count=4. Aux writes drain in order r7..r10 after the pipe burst ends; r11 is accepted as soon as a slot frees.
- Pipe_Reg=0 and Aux_Reg=0 requests -> Register_Write stays 0. The aux transfer is consumed, Fifo_Count stays 0, and Pending_Mask[0] stays 0.
- Reset asserted mid-cycle with 3 entries queued -> outputs, Fifo_Count, and Pending_Mask go to 0 immediately. No queued write appears after release.
- With REGWB_AUX_BYPASS_EN: single aux write r9=0x55 into an idle arbiter -> Register_Write high in the next cycle and Fifo_Count stays 0. Without the macro, the same stimulus gives a write one cycle later.
